// File: rtl/id_stage_reg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | id_stage_reg : fetch->decode pipeline register with immediate slicing |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module id_stage_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013,
  parameter logic [31:0] RESET_PC  = 32'h00000000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [11:0] iimm,
  output logic [11:0] simm,
  output logic [11:0] bimm,
  output logic [19:0] uimm,
  output logic [19:0] jimm,
  output logic [5:0]  EXTOp,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic        illegal
);

  localparam logic [5:0] c_EXT_SHAMT = 6'b100000;
  localparam logic [5:0] c_EXT_ITYPE = 6'b010000;
  localparam logic [5:0] c_EXT_STYPE = 6'b001000;
  localparam logic [5:0] c_EXT_BTYPE = 6'b000100;
  localparam logic [5:0] c_EXT_UTYPE = 6'b000010;
  localparam logic [5:0] c_EXT_JTYPE = 6'b000001;
  localparam logic [5:0] c_EXT_NONE  = 6'b000000;

  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic [5:0]  r_extop;
  logic        r_illegal;

  logic [5:0]  w_extop;
  logic        w_illegal;
  logic        w_accept;

  assign in_ready = flush | ~r_valid | out_ready;
  assign w_accept = in_valid & in_ready & ~flush;

  // Opcode decode happens on the incoming instruction so that EXTOp is a flop output.
  always_comb begin
    w_extop   = c_EXT_NONE;
    w_illegal = 1'b0;
    case (in_instr[6:0])
      7'b0010011: w_extop = (in_instr[14:12] == 3'b001 || in_instr[14:12] == 3'b101)
                            ? c_EXT_SHAMT : c_EXT_ITYPE;
      7'b0000011,
      7'b1100111: w_extop = c_EXT_ITYPE;
      7'b0100011: w_extop = c_EXT_STYPE;
      7'b1100011: w_extop = c_EXT_BTYPE;
      7'b0110111,
      7'b0010111: w_extop = c_EXT_UTYPE;
      7'b1101111: w_extop = c_EXT_JTYPE;
      7'b0110011,
      7'b0001111,
      7'b1110011: w_extop = c_EXT_NONE;
      default:    w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      r_valid   <= 1'b0;
      r_instr   <= NOP_INSTR;
      r_pc      <= RESET_PC;
      r_extop   <= c_EXT_ITYPE;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_instr   <= in_instr;
      r_pc      <= in_pc;
      r_extop   <= w_extop;
      r_illegal <= w_illegal;
    end else if (out_ready) begin
      r_valid   <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_instr = r_instr;
  assign out_pc    = r_pc;
  assign EXTOp     = r_extop;
  assign illegal   = r_illegal;

  // Raw field slices; sign extension belongs to the extender.
  assign iimm   = r_instr[31:20];
  assign simm   = {r_instr[31:25], r_instr[11:7]};
  assign bimm   = {r_instr[31], r_instr[7], r_instr[30:25], r_instr[11:8]};
  assign uimm   = r_instr[31:12];
  assign jimm   = {r_instr[31], r_instr[19:12], r_instr[20], r_instr[30:21]};
  assign rs1    = r_instr[19:15];
  assign rs2    = r_instr[24:20];
  assign rd     = r_instr[11:7];
  assign funct3 = r_instr[14:12];
  assign funct7 = r_instr[31:25];

endmodule
`default_nettype wire

// File: tb/tb_id_stage_reg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_id_stage_reg : directed self-checking bench for id_stage_reg       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_id_stage_reg;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [11:0] iimm;
  logic [11:0] simm;
  logic [11:0] bimm;
  logic [19:0] uimm;
  logic [19:0] jimm;
  logic [5:0]  EXTOp;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        illegal;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] c_INSTR_A = 32'h00A00093;  // addi x1,x0,10
  localparam logic [31:0] c_INSTR_B = 32'h01400113;  // addi x2,x0,20

  id_stage_reg u_dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .iimm      (iimm),
    .simm      (simm),
    .bimm      (bimm),
    .uimm      (uimm),
    .jimm      (jimm),
    .EXTOp     (EXTOp),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .funct3    (funct3),
    .funct7    (funct7),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_instr  = instr;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    #1;
  endtask

  task automatic check_bubble(input string tag);
    check({tag, "_valid"},   32'(out_valid), 32'h0);
    check({tag, "_instr"},   out_instr,      32'h00000013);
    check({tag, "_pc"},      out_pc,         32'h0);
    check({tag, "_extop"},   32'(EXTOp),     32'h10);
    check({tag, "_illegal"}, 32'(illegal),   32'h0);
  endtask

  task automatic check_lw(input string tag);
    check({tag, "_valid"},  32'(out_valid), 32'h1);
    check({tag, "_pc"},     out_pc,         32'h100);
    check({tag, "_iimm"},   32'(iimm),      32'hFFC);
    check({tag, "_extop"},  32'(EXTOp),     32'h10);
    check({tag, "_rs1"},    32'(rs1),       32'd2);
    check({tag, "_rd"},     32'(rd),        32'd1);
    check({tag, "_funct3"}, 32'(funct3),    32'd2);
    check({tag, "_ill"},    32'(illegal),   32'h0);
  endtask

  initial begin
    rstn = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    check_bubble("rst");
    check("rst_iimm",   32'(iimm),   32'h0);
    check("rst_rd",     32'(rd),     32'h0);
    check("rst_rs1",    32'(rs1),    32'h0);
    check("rst_funct3", 32'(funct3), 32'h0);

    // Scenario 1: lw x1,-4(x2)
    rstn = 1'b1;
    drive(1'b1, 32'hFFC12083, 32'h100, 1'b1, 1'b0);
    check("s1_in_ready", 32'(in_ready), 32'h1);
    tick();
    check_lw("s1");

    // Back-to-back slli then beq
    drive(1'b1, 32'h00331293, 32'h104, 1'b1, 1'b0);
    tick();
    check("slli_valid", 32'(out_valid), 32'h1);
    check("slli_extop", 32'(EXTOp),     32'h20);
    check("slli_iimm",  32'(iimm),      32'h003);
    check("slli_rd",    32'(rd),        32'd5);
    check("slli_rs1",   32'(rs1),       32'd6);
    drive(1'b1, 32'hFE208CE3, 32'h108, 1'b1, 1'b0);
    tick();
    check("beq_valid", 32'(out_valid), 32'h1);
    check("beq_pc",    out_pc,         32'h108);
    check("beq_extop", 32'(EXTOp),     32'h04);
    check("beq_bimm",  32'(bimm),      32'hFFC);
    check("beq_rs1",   32'(rs1),       32'd1);
    check("beq_rs2",   32'(rs2),       32'd2);
    check("beq_f7",    32'(funct7),    32'h7F);

    // Stall: A held while B waits
    drive(1'b1, c_INSTR_A, 32'h200, 1'b1, 1'b0);
    tick();
    drive(1'b1, c_INSTR_B, 32'h204, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("stall_in_ready", 32'(in_ready), 32'h0);
      tick();
      check("stall_valid", 32'(out_valid), 32'h1);
      check("stall_instr", out_instr,      c_INSTR_A);
      check("stall_pc",    out_pc,         32'h200);
      check("stall_iimm",  32'(iimm),      32'h00A);
    end
    drive(1'b1, c_INSTR_B, 32'h204, 1'b1, 1'b0);
    check("unstall_in_ready", 32'(in_ready), 32'h1);
    tick();
    check("unstall_valid", 32'(out_valid), 32'h1);
    check("unstall_instr", out_instr,      c_INSTR_B);
    check("unstall_pc",    out_pc,         32'h204);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    check("drain_valid", 32'(out_valid), 32'h0);

    // Flush while A held and B offered
    drive(1'b1, c_INSTR_A, 32'h300, 1'b1, 1'b0);
    tick();
    check("preflush_instr", out_instr, c_INSTR_A);
    drive(1'b1, c_INSTR_B, 32'h304, 1'b0, 1'b1);
    check("flush_in_ready", 32'(in_ready), 32'h1);
    tick();
    check_bubble("flush");
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    check("postflush_valid", 32'(out_valid), 32'h0);
    check("postflush_instr", out_instr,      32'h00000013);

    // Illegal, R-type, U and J decode
    drive(1'b1, 32'h0000007F, 32'h400, 1'b1, 1'b0);
    tick();
    check("ill_valid",   32'(out_valid), 32'h1);
    check("ill_illegal", 32'(illegal),   32'h1);
    check("ill_extop",   32'(EXTOp),     32'h00);
    drive(1'b1, 32'h002081B3, 32'h404, 1'b1, 1'b0);
    tick();
    check("add_illegal", 32'(illegal), 32'h0);
    check("add_extop",   32'(EXTOp),   32'h00);
    check("add_rd",      32'(rd),      32'd3);
    drive(1'b1, 32'h123450B7, 32'h408, 1'b1, 1'b0);
    tick();
    check("lui_extop", 32'(EXTOp),   32'h02);
    check("lui_uimm",  32'(uimm),    32'h12345);
    check("lui_rd",    32'(rd),      32'd1);
    check("lui_ill",   32'(illegal), 32'h0);
    drive(1'b1, 32'h0080006F, 32'h40C, 1'b1, 1'b0);
    tick();
    check("jal_extop", 32'(EXTOp), 32'h01);
    check("jal_jimm",  32'(jimm),  32'h00004);
    check("jal_pc",    out_pc,     32'h40C);

    // Store immediate slicing: sw x5,-12(x2) = 0xFE512A23
    drive(1'b1, 32'hFE512A23, 32'h410, 1'b1, 1'b0);
    tick();
    check("sw_extop", 32'(EXTOp), 32'h08);
    check("sw_simm",  32'(simm),  32'hFF4);

    // Reset while a stalled instruction is held
    drive(1'b1, c_INSTR_A, 32'h500, 1'b1, 1'b0);
    tick();
    drive(1'b1, c_INSTR_B, 32'h504, 1'b0, 1'b0);
    rstn = 1'b0;
    tick();
    check_bubble("midrst");
    rstn = 1'b1;
    drive(1'b1, 32'hFFC12083, 32'h100, 1'b1, 1'b0);
    tick();
    check_lw("postrst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_stage_reg.md
Name: id_stage_reg

Overview:
- Instruction-decode pipeline register between instruction fetch and the immediate extender/execute stage.
- Accepts a fetched instruction and PC over a valid/ready handshake and slices out the immediate fields (iimm, simm, bimm, uimm, jimm).
- Decodes the opcode into the 6-bit EXTOp select and presents everything registered, one cycle later, to the extender, register file and execute stage.
- Supports back-pressure (stall) and flush (bubble insertion on taken branch/jump).

Parameters:
- NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0) loaded on reset and flush.
- RESET_PC, 32'h00000000, PC value held in the bubble.

Ports:
- clk  in  1  rising-edge clock
- rstn  in  1  synchronous reset, active low
- in_valid  in  1  fetch presents a valid instruction
- in_ready  out  1  stage can accept this cycle
- in_instr  in  32  fetched instruction
- in_pc  in  32  PC of in_instr
- flush  in  1  kill held and incoming instruction
- out_valid  out  1  registered instruction valid
- out_ready  in  1  downstream consumes this cycle
- out_instr  out  32  registered instruction
- out_pc  out  32  registered PC
- iimm  out  12  instr[31:20]
- simm  out  12  {instr[31:25], instr[11:7]}
- bimm  out  12  {instr[31], instr[7], instr[30:25], instr[11:8]}
- uimm  out  20  instr[31:12]
- jimm  out  20  {instr[31], instr[19:12], instr[20], instr[30:21]}
- EXTOp  out  6  extender select
- rs1, rs2, rd  out  5 each  register specifiers
- funct3  out  3
- funct7  out  7
- illegal  out  1  unrecognised opcode

Behaviour:
- Reset (rstn=0 at a clk edge) loads the bubble:
  - out_valid=0, illegal=0, out_pc=RESET_PC, out_instr=NOP_INSTR.
  - All field outputs decode from NOP_INSTR: iimm=0, rd=rs1=0, funct3=0, EXTOp=ITYPE.
  - Reset overrides flush and capture. Reset mid-stall discards the held instruction.
- in_ready is combinational: in_ready = flush | ~out_valid | out_ready.
- Transfer in: in_valid & in_ready & ~flush. At the next edge all outputs load from the decode of in_instr/in_pc, and out_valid=1.
- Latency: exactly one cycle from input acceptance to out_valid.
- Hold: out_valid & ~out_ready & ~flush keeps every output stable, including all decoded fields.
- Drain: out_valid & out_ready with no new input gives out_valid=0 next cycle. Data outputs may keep their last value.
- Flush (highest priority after reset):
  - Next edge loads the bubble (out_valid=0).
  - Any in_valid instruction presented that cycle is dropped; fetch sees in_ready=1 and treats it as consumed.
- Simultaneous consume and accept (out_valid & out_ready & in_valid): the new instruction replaces the old one with no bubble, giving full throughput of one instruction per cycle.
- Field slicing is pure bit selection from the instruction, with no sign extension; the extender does the extension.
- EXTOp encoding: SHAMT=6'b100000, ITYPE=6'b010000, STYPE=6'b001000, BTYPE=6'b000100, UTYPE=6'b000010, JTYPE=6'b000001, none=6'b000000.
- Decode by opcode instr[6:0]:
  - 0010011 with funct3 001 or 101: SHAMT. Other funct3: ITYPE.
  - 0000011, 1100111: ITYPE.
  - 0100011: STYPE.
  - 1100011: BTYPE.
  - 0110111, 0010111: UTYPE.
  - 1101111: JTYPE.
  - 0110011, 0001111, 1110011: none, illegal=0.
  - Any other opcode: none, illegal=1. The instruction still transfers with out_valid=1; downstream decides the trap.
- illegal is meaningful only while out_valid=1.

Test Plan:
- Reset, then in_valid with in_instr=0xFFC12083 (lw x1,-4(x2)), in_pc=0x100, out_ready=1 -> next cycle out_valid=1, out_pc=0x100, iimm=0xFFC, EXTOp=010000, rs1=2, rd=1, funct3=010, illegal=0.
- in_instr=0x00331293 (slli x5,x6,3) -> EXTOp=100000, iimm=0x003, rd=5, rs1=6. Then 0xFE208CE3 (beq x1,x2,-8) on the next cycle -> EXTOp=000100, bimm=0xFFC, rs1=1, rs2=2, back-to-back with out_valid held at 1.
- Stall:
  - Hold out_ready=0 for 3 cycles while in_valid=1 with instr B and instr A held -> in_ready=0, outputs stay A.
  - Raise out_ready -> A consumed, B appears the next cycle. No loss or duplication.
- Flush with out_valid=1 (A held, out_ready=0) and in_valid=1 (B) -> in_ready=1. Next cycle out_valid=0, out_instr=0x00000013, EXTOp=010000. Neither A nor B ever appears.
- Illegal and U/J decode:
  - 0x0000007F -> out_valid=1, illegal=1, EXTOp=000000.
  - 0x123450B7 (lui x1,0x12345) -> EXTOp=000010, uimm=0x12345.
  - 0x0080006F (jal x0,8) -> EXTOp=000001, jimm=0x00004.
- Assert rstn=0 for one cycle while a stalled instruction is held -> next cycle out_valid=0, out_pc=0, out_instr=NOP. After release, the first accepted instruction behaves as in scenario 1.
